// File: rtl/collision_scheduler.sv
// collision_scheduler: time-multiplexes one shared pipe-collision checker
// across NUM_PIPES on-screen slots. On each accepted frame_tick it walks
// every slot once. For each active slot it selects the slot, clears the
// checker, strobes evaluate and then samples the hit. Hits set a sticky
// game_over flag.
// Optional build macro: FLOOR_CHECK_EN. When it is defined, a bird at or
// below FLOOR_Y also counts as a hit, checked once at the end of each scan.
module collision_scheduler #(
  parameter int NUM_PIPES = 3,
  parameter int IDX_W     = 2,
  parameter int FLOOR_Y   = 116
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 frame_tick,
  input  logic [NUM_PIPES-1:0] pipe_valid,
  input  logic                 chk_hit,
  input  logic [6:0]           y_bird,
  input  logic                 game_restart,
  output logic [IDX_W-1:0]     chk_sel,
  output logic                 chk_clear,
  output logic                 chk_eval,
  output logic                 busy,
  output logic                 scan_done,
  output logic [IDX_W-1:0]     hit_idx,
  output logic                 game_over
);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_FIND   = 3'd1;
  localparam logic [2:0] S_CLEAR  = 3'd2;
  localparam logic [2:0] S_EVAL   = 3'd3;
  localparam logic [2:0] S_SAMPLE = 3'd4;
  localparam logic [2:0] S_DONE   = 3'd5;

  // The index carries one extra bit so that idx == NUM_PIPES is the
  // natural end-of-scan value and never wraps back onto slot 0.
  localparam int            IW   = IDX_W + 1;
  localparam logic [IW-1:0] LAST = NUM_PIPES[IW-1:0];

  logic [2:0]       state_q,     state_d;
  logic [IW-1:0]    idx_q,       idx_d;
  logic             hit_seen_q,  hit_seen_d;
  logic [IDX_W-1:0] chk_sel_q,   chk_sel_d;
  logic             chk_clear_q, chk_clear_d;
  logic             chk_eval_q,  chk_eval_d;
  logic             busy_q,      busy_d;
  logic             scan_done_q, scan_done_d;
  logic [IDX_W-1:0] hit_idx_q,   hit_idx_d;
  logic             game_over_q, game_over_d;

  // pipe_valid is zero-extended so that any idx value can index it safely.
  // Slots past NUM_PIPES read as inactive.
  logic [(2**IW)-1:0] valid_ext;

`ifdef FLOOR_CHECK_EN
  localparam logic [6:0] FLOOR_Y7 = FLOOR_Y[6:0];
`else
  logic unused_floor;
  assign unused_floor = ^{y_bird, FLOOR_Y[6:0]};
`endif

  // Widen pipe_valid to the full index range.
  always_comb begin
    valid_ext                = '0;
    valid_ext[NUM_PIPES-1:0] = pipe_valid;
  end

  // Scan sequencing, hit accumulation and registered-output next values.
  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    hit_seen_d  = hit_seen_q;
    chk_sel_d   = chk_sel_q;
    hit_idx_d   = hit_idx_q;
    game_over_d = game_over_q;

    // A restart clears first, so a hit in the same cycle still wins below.
    if (game_restart) begin
      game_over_d = 1'b0;
      hit_idx_d   = '0;
    end

    case (state_q)
      S_IDLE: begin
        if (frame_tick && !game_over_q) begin
          idx_d      = '0;
          hit_seen_d = 1'b0;
          state_d    = S_FIND;
        end
      end
      S_FIND: begin
        if (idx_q >= LAST) begin
          state_d = S_DONE;
        end else if (!valid_ext[idx_q]) begin
          idx_d = idx_q + 1'b1;
        end else begin
          chk_sel_d = idx_q[IDX_W-1:0];
          state_d   = S_CLEAR;
        end
      end
      S_CLEAR: state_d = S_EVAL;
      S_EVAL:  state_d = S_SAMPLE;
      S_SAMPLE: begin
        if (chk_hit) begin
          game_over_d = 1'b1;
          if (!hit_seen_q) begin
            hit_idx_d  = idx_q[IDX_W-1:0];
            hit_seen_d = 1'b1;
          end
        end
        idx_d   = idx_q + 1'b1;
        state_d = S_FIND;
      end
      S_DONE: begin
`ifdef FLOOR_CHECK_EN
        if (y_bird >= FLOOR_Y7) begin
          game_over_d = 1'b1;
          if (!hit_seen_q) hit_idx_d = '1;
        end
`endif
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    // Strobe outputs are registered decodes of the upcoming state.
    chk_clear_d = (state_d == S_CLEAR);
    chk_eval_d  = (state_d == S_EVAL);
    busy_d      = (state_d != S_IDLE);
    scan_done_d = (state_d == S_DONE);
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= S_IDLE;
      idx_q       <= '0;
      hit_seen_q  <= 1'b0;
      chk_sel_q   <= '0;
      chk_clear_q <= 1'b0;
      chk_eval_q  <= 1'b0;
      busy_q      <= 1'b0;
      scan_done_q <= 1'b0;
      hit_idx_q   <= '0;
      game_over_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      hit_seen_q  <= hit_seen_d;
      chk_sel_q   <= chk_sel_d;
      chk_clear_q <= chk_clear_d;
      chk_eval_q  <= chk_eval_d;
      busy_q      <= busy_d;
      scan_done_q <= scan_done_d;
      hit_idx_q   <= hit_idx_d;
      game_over_q <= game_over_d;
    end
  end

  assign chk_sel   = chk_sel_q;
  assign chk_clear = chk_clear_q;
  assign chk_eval  = chk_eval_q;
  assign busy      = busy_q;
  assign scan_done = scan_done_q;
  assign hit_idx   = hit_idx_q;
  assign game_over = game_over_q;

endmodule

// File: tb/tb_collision_scheduler.sv
// Bench for collision_scheduler. It has three parts: a vector table,
// hand-written corner sequences, and a randomized phase that is checked
// against a scan-level reference model.
module tb_collision_scheduler;
  localparam int NP    = 3;
  localparam int IDX_W = 2;

  logic             clk = 1'b0;
  logic             reset;
  logic             frame_tick;
  logic [NP-1:0]    pipe_valid;
  logic             chk_hit;
  logic [6:0]       y_bird;
  logic             game_restart;
  logic [IDX_W-1:0] chk_sel;
  logic             chk_clear;
  logic             chk_eval;
  logic             busy;
  logic             scan_done;
  logic [IDX_W-1:0] hit_idx;
  logic             game_over;

  collision_scheduler dut (
    .clk(clk), .reset(reset), .frame_tick(frame_tick), .pipe_valid(pipe_valid),
    .chk_hit(chk_hit), .y_bird(y_bird), .game_restart(game_restart),
    .chk_sel(chk_sel), .chk_clear(chk_clear), .chk_eval(chk_eval), .busy(busy),
    .scan_done(scan_done), .hit_idx(hit_idx), .game_over(game_over)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  int evq[$];
  int lat;
  int nclr;

  int m_go;
  int m_hidx;

  typedef struct {
    logic [2:0] pv;
    logic [2:0] hm;
    logic       rw;
    int         lat;
    int         go;
    int         hidx;
  } vec_t;
  vec_t tbl[7];

  task automatic chk(input string nm, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  // The bench plays the checker here. chk_hit (and optionally game_restart)
  // is driven only in the cycle after chk_eval was seen, which is SAMPLE.
  task automatic do_scan(input logic [2:0] pv, input logic [2:0] hm, input logic rw);
    logic             pend;
    logic [IDX_W-1:0] s;
    pend = 1'b0;
    s    = '0;
    evq.delete();
    lat  = 0;
    nclr = 0;
    @(negedge clk);
    pipe_valid = pv;
    frame_tick = 1'b1;
    for (int k = 1; k <= 60; k++) begin
      @(negedge clk);
      frame_tick   = 1'b0;
      chk_hit      = 1'b0;
      game_restart = 1'b0;
      if (pend) begin
        chk_hit      = hm[s];
        game_restart = rw & hm[s];
        pend         = 1'b0;
      end
      if (chk_clear) nclr++;
      if (chk_eval) begin
        evq.push_back(int'(chk_sel));
        s    = chk_sel;
        pend = 1'b1;
      end
      if (scan_done) begin
        lat = k;
        break;
      end
    end
    chk_hit      = 1'b0;
    game_restart = 1'b0;
  endtask

  task automatic restart_pulse();
    @(negedge clk);
    game_restart = 1'b1;
    @(negedge clk);
    game_restart = 1'b0;
    m_go   = 0;
    m_hidx = 0;
  endtask

  // The scan result is predicted from the rules directly.
  // Latency is one plus one FIND per slot plus the end check, plus three
  // cycles per active slot. Evaluation order is ascending over the active
  // slots. The first hit of the scan names hit_idx.
  task automatic check_scan(input string tag, input logic [2:0] pv, input logic [2:0] hm,
                            input logic rw);
    int exp_seq;
    int got_seq;
    int n;
    int seen;
    exp_seq = 0;
    got_seq = 0;
    n       = 0;
    seen    = 0;
    for (int i = 0; i < NP; i++) begin
      if (pv[i]) begin
        exp_seq = exp_seq * 4 + (i + 1);
        n++;
        if (hm[i]) begin
          if (rw) begin
            m_go   = 0;
            m_hidx = 0;
          end
          m_go = 1;
          if (seen == 0) begin
            m_hidx = i;
            seen   = 1;
          end
        end
      end
    end
`ifdef FLOOR_CHECK_EN
    if (y_bird >= 7'd116) begin
      m_go = 1;
      if (seen == 0) m_hidx = 3;
    end
`endif
    foreach (evq[j]) got_seq = got_seq * 4 + (evq[j] + 1);
    chk({tag, "_latency"}, lat, 1 + (NP + 1) + 3 * n);
    chk({tag, "_eval_order"}, got_seq, exp_seq);
    chk({tag, "_clear_count"}, nclr, n);
    chk({tag, "_game_over"}, int'(game_over), m_go);
    chk({tag, "_hit_idx"}, int'(hit_idx), m_hidx);
  endtask

  initial begin
    int seen_done;
    int seen_busy;
    logic [2:0] rpv;
    logic [2:0] rhm;
    logic       rrw;

    tbl[0] = '{3'b111, 3'b000, 1'b0, 14, 0, 0};
    tbl[1] = '{3'b101, 3'b000, 1'b0, 11, 0, 0};
    tbl[2] = '{3'b111, 3'b110, 1'b0, 14, 1, 1};
    tbl[3] = '{3'b000, 3'b111, 1'b0,  5, 0, 0};
    tbl[4] = '{3'b011, 3'b110, 1'b0, 11, 1, 1};
    tbl[5] = '{3'b100, 3'b100, 1'b0,  8, 1, 2};
    tbl[6] = '{3'b111, 3'b010, 1'b1, 14, 1, 1};

    reset        = 1'b1;
    frame_tick   = 1'b0;
    pipe_valid   = '0;
    chk_hit      = 1'b0;
    y_bird       = 7'd0;
    game_restart = 1'b0;
    m_go         = 0;
    m_hidx       = 0;
    repeat (3) @(negedge clk);
    chk("rst_chk_sel", int'(chk_sel), 0);
    chk("rst_chk_clear", int'(chk_clear), 0);
    chk("rst_chk_eval", int'(chk_eval), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_scan_done", int'(scan_done), 0);
    chk("rst_hit_idx", int'(hit_idx), 0);
    chk("rst_game_over", int'(game_over), 0);
    reset = 1'b0;

    // Vector table: the expected values here are constants.
    for (int t = 0; t < 7; t++) begin
      int seq;
      int exp_seq;
      restart_pulse();
      chk("tbl_restart_go", int'(game_over), 0);
      do_scan(tbl[t].pv, tbl[t].hm, tbl[t].rw);
      seq     = 0;
      exp_seq = 0;
      foreach (evq[j]) seq = seq * 4 + (evq[j] + 1);
      for (int i = 0; i < NP; i++) if (tbl[t].pv[i]) exp_seq = exp_seq * 4 + (i + 1);
      chk($sformatf("tbl%0d_latency", t), lat, tbl[t].lat);
      chk($sformatf("tbl%0d_eval_order", t), seq, exp_seq);
      chk($sformatf("tbl%0d_game_over", t), int'(game_over), tbl[t].go);
      chk($sformatf("tbl%0d_hit_idx", t), int'(hit_idx), tbl[t].hidx);
    end

    // With game_over set, a frame_tick must not start a scan.
    @(negedge clk);
    frame_tick = 1'b1;
    pipe_valid = 3'b111;
    seen_busy  = 0;
    @(negedge clk);
    frame_tick = 1'b0;
    for (int k = 0; k < 6; k++) begin
      if (busy) seen_busy++;
      @(negedge clk);
    end
    chk("ignored_tick_busy", seen_busy, 0);

    // A restart on its own clears both game_over and hit_idx.
    restart_pulse();
    chk("restart_go", int'(game_over), 0);
    chk("restart_hit_idx", int'(hit_idx), 0);

    // Reset in the EVAL of slot 1 aborts the scan without a scan_done.
    @(negedge clk);
    pipe_valid = 3'b111;
    frame_tick = 1'b1;
    seen_done  = 0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      frame_tick = 1'b0;
      if (chk_eval && chk_sel == 2'd1) break;
    end
    chk("midrst_reached_eval1", int'(chk_eval && chk_sel == 2'd1), 1);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    chk("midrst_eval", int'(chk_eval), 0);
    chk("midrst_busy", int'(busy), 0);
    chk("midrst_chk_sel", int'(chk_sel), 0);
    for (int k = 0; k < 20; k++) begin
      if (scan_done || busy) seen_done++;
      @(negedge clk);
    end
    chk("midrst_no_done", seen_done, 0);

`ifdef FLOOR_CHECK_EN
    // Floor check at its boundary, with no pipes active.
    y_bird = 7'd116;
    restart_pulse();
    do_scan(3'b000, 3'b000, 1'b0);
    chk("floor116_go", int'(game_over), 1);
    chk("floor116_hit_idx", int'(hit_idx), 3);
    y_bird = 7'd115;
    restart_pulse();
    do_scan(3'b000, 3'b000, 1'b0);
    chk("floor115_go", int'(game_over), 0);
    y_bird = 7'd0;
`endif

    // Randomized scans checked against the reference model.
    restart_pulse();
    for (int r = 0; r < 40; r++) begin
      if ($urandom_range(0, 2) == 0) restart_pulse();
      rpv    = 3'($urandom_range(0, 7));
      rhm    = 3'($urandom_range(0, 7));
      rrw    = ($urandom_range(0, 3) == 0);
      y_bird = 7'($urandom_range(100, 127));
      if (m_go != 0) begin
        do_scan(rpv, rhm, rrw);
        chk("rand_ignored_scan", lat, 0);
        chk("rand_ignored_go", int'(game_over), 1);
      end else begin
        do_scan(rpv, rhm, rrw);
        check_scan("rand", rpv, rhm, rrw);
      end
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
